// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: in-order imem reads, PC-tagged return queue,
// and a flush that discards buffered and in-flight fetches.
module inst_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_addr,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          inst_valid,
  output logic [31:0]   inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] CAP = (PW+1)'(DEPTH);

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] drop_cnt;
  logic [PW-1:0] occ;
  logic [PW-1:0] out;
  logic [PW:0]   load;

  logic [AW-1:0]    pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] filled;

  logic [IW-1:0] a_idx;
  logic [IW-1:0] f_idx;
  logic [IW-1:0] h_idx;

  logic accept;
  logic pop;
  logic live;
  logic drop_hit;
  logic fill_hit;

  assign a_idx = alloc_ptr[IW-1:0];
  assign f_idx = fill_ptr[IW-1:0];
  assign h_idx = head_ptr[IW-1:0];

  assign occ  = alloc_ptr - head_ptr;
  assign out  = alloc_ptr - fill_ptr;
  assign load = {1'b0, occ} + {1'b0, drop_cnt};

  // Pending drops hold slots so stale responses can never overrun the buffer.
  assign pc_ready  = !rst && !flush && (load < CAP);
  assign accept    = pc_valid && pc_ready;
  assign imem_req  = accept;
  assign imem_addr = {pc_addr[AW-1:2], 2'b00};

  assign drop_hit = imem_rvalid && (drop_cnt != '0);
  assign fill_hit = imem_rvalid && (drop_cnt == '0) && (out != '0);
  assign live     = drop_hit || fill_hit;

  assign inst_valid = !rst && filled[h_idx] && (occ != '0);
  assign inst_data  = data_mem[h_idx];
  assign inst_pc    = pc_mem[h_idx];
  assign pop        = inst_valid && inst_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      filled    <= '0;
      drop_cnt  <= drop_cnt + out - {{IW{1'b0}}, live};
    end else begin
      if (accept) begin
        pc_mem[a_idx] <= pc_addr;
        filled[a_idx] <= 1'b0;
        alloc_ptr     <= alloc_ptr + 1'b1;
      end
      if (drop_hit) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (fill_hit) begin
        data_mem[f_idx] <= imem_rdata;
        filled[f_idx]   <= 1'b1;
        fill_ptr        <= fill_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: queue-based reference model, in-order
// latency memory model, vector table and directed corner sequences.
module tb_inst_fetch_buf;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam logic [31:0] XK = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_addr = '0;
  logic          pc_valid = 1'b0;
  logic          pc_ready;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          inst_valid;
  logic [31:0]   inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;

  inst_fetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .pc_addr(pc_addr),
    .pc_valid(pc_valid),
    .pc_ready(pc_ready),
    .flush(flush),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_data(inst_data),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          f;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  ent_t  q[$];
  mreq_t mq[$];
  vec_t  tbl[5];

  int drop = 0;
  int cyc = 0;
  int lat = 1;
  int total = 0;
  int bad = 0;
  int ndeliv = 0;
  int nacc = 0;
  int first;

  logic [31:0] last_pc = '0;
  logic [31:0] last_data = '0;
  logic [31:0] s_iaddr;
  bit s_iv;
  bit s_pr;
  bit s_req;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input bit v, input logic [31:0] a, input bit rdy,
                      input bit fl, input bit r);
    bit pr;
    bit iv;
    bit lv;
    int unf;
    rst = r;
    pc_valid = v;
    pc_addr = a;
    inst_ready = rdy;
    flush = fl;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = mq[0].a ^ XK;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    pr = !r && !fl && (q.size() + drop < DEPTH);
    iv = !r && q.size() > 0 && q[0].f;
    chk("pc_ready", 32'(pc_ready), 32'(pr));
    chk("imem_req", 32'(imem_req), 32'(v && pr));
    if (v && pr) chk("imem_addr", imem_addr, a & ~32'h3);
    chk("inst_valid", 32'(inst_valid), 32'(iv));
    if (iv) begin
      chk("inst_pc", inst_pc, q[0].pc);
      chk("inst_data", inst_data, q[0].d);
    end
    chk("drop_cnt", 32'(dut.drop_cnt), drop);
    s_iv = inst_valid;
    s_pr = pc_ready;
    s_req = imem_req;
    s_iaddr = imem_addr;
    if (!r && imem_req) nacc++;
    if (!r && !fl && inst_valid && rdy) begin
      ndeliv++;
      last_pc = inst_pc;
      last_data = inst_data;
    end
    if (r) begin
      q.delete();
      mq.delete();
      drop = 0;
    end else begin
      unf = 0;
      foreach (q[i]) if (!q[i].f) unf++;
      lv = imem_rvalid && (drop > 0 || unf > 0);
      if (imem_rvalid) void'(mq.pop_front());
      if (fl) begin
        drop = drop + unf - (lv ? 1 : 0);
        q.delete();
      end else begin
        if (imem_rvalid) begin
          if (drop > 0) begin
            drop--;
          end else begin
            for (int i = 0; i < q.size(); i++) begin
              if (!q[i].f) begin
                q[i].f = 1'b1;
                q[i].d = imem_rdata;
                break;
              end
            end
          end
        end
        if (iv && rdy) void'(q.pop_front());
        if (v && pr) q.push_back('{a, 1'b0, 32'h0});
      end
      if (v && pr) mq.push_back('{a & ~32'h3, cyc + lat});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    pc_valid = 1'b0;
    flush = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_pc_ready", 32'(pc_ready), 32'h1);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_1002, 32'h0000_1000, 32'hA5A5_1000};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h5A5A_FFFC};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 32'hA5A5_0000};
    tbl[3] = '{32'h8000_0001, 32'h8000_0000, 32'h25A5_0000};
    tbl[4] = '{32'h1234_5677, 32'h1234_5674, 32'hB791_5674};

    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      lat = 1;
      do_reset();
      step(1'b1, tbl[k].a, 1'b1, 1'b0, 1'b0);
      chk("tbl_req", 32'(s_req), 32'h1);
      chk("tbl_iaddr", s_iaddr, tbl[k].ea);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("tbl_pc", last_pc, tbl[k].a);
      chk("tbl_data", last_data, tbl[k].ed);
    end

    lat = 1;
    do_reset();
    ndeliv = 0;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
      if (s_iv && first < 0) first = i;
    end
    chk("stream_lat", first, 2);
    chk("stream_cnt", ndeliv, 10);

    do_reset();
    nacc = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    chk("bp_acc", nacc, 4);
    chk("bp_full", 32'(s_pr), 32'h0);
    ndeliv = 0;
    step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    chk("bp_pop_n", ndeliv, 1);
    chk("bp_pop_pc", last_pc, 32'h0);
    chk("bp_pop_noacc", nacc, 4);
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    chk("bp_reacc", nacc, 5);
    step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    chk("bp_refull", nacc, 5);

    lat = 4;
    do_reset();
    step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h18, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h1C, 1'b1, 1'b1, 1'b0);
    chk("fl_noacc", 32'(s_req), 32'h0);
    chk("fl_drop3", 32'(dut.drop_cnt), 32'h3);
    ndeliv = 0;
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    chk("fl_acc", 32'(s_req), 32'h1);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("fl_n", ndeliv, 1);
    chk("fl_pc", last_pc, 32'h100);
    chk("fl_data", last_data, 32'hA5A5_0100);

    lat = 2;
    do_reset();
    step(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h28, 1'b1, 1'b0, 1'b0);
    ndeliv = 0;
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("fc_was_valid", 32'(s_iv), 32'h1);
    chk("fc_drop", 32'(dut.drop_cnt), 32'h1);
    chk("fc_deliv", ndeliv, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("fc_valid", 32'(s_iv), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("fc_deliv2", ndeliv, 0);

    lat = $urandom_range(1, 3);
    do_reset();
    nacc = 0;
    ndeliv = 0;
    for (int i = 0; i < 400 && nacc < 20; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
           1'b0, 1'b0);
    end
    for (int i = 0; i < 100 && ndeliv < 20; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("rnd_acc", nacc, 20);
    chk("rnd_deliv", ndeliv, 20);
    chk("rnd_empty", 32'(q.size()), 32'h0);

    lat = 1;
    do_reset();
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
    ndeliv = 0;
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
    chk("rs_valid", 32'(s_iv), 32'h0);
    chk("rs_ready", 32'(s_pr), 32'h0);
    chk("rs_req", 32'(s_req), 32'h0);
    step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    chk("rs_acc", 32'(s_req), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rs_n", ndeliv, 1);
    chk("rs_pc", last_pc, 32'h200);
    chk("rs_data", last_data, 32'hA5A5_0200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
